// File: rtl/vertex_xform_ctrl.sv
// Sequencer for the 4x4 vertex transform datapath: double-buffered matrix,
// credit-checked vertex issue and a first-word-fall-through result FIFO.
module vertex_xform_ctrl #(
  parameter int unsigned LAT        = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CW         = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cfg_wr,
  input  logic [3:0]   cfg_addr,
  input  logic [31:0]  cfg_data,
  input  logic         cfg_commit,
  output logic         cfg_done,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_x,
  input  logic [31:0]  in_y,
  input  logic [31:0]  in_z,
  output logic         dp_issue,
  output logic [31:0]  dp_x,
  output logic [31:0]  dp_y,
  output logic [31:0]  dp_z,
  output logic [511:0] dp_matrix,
  input  logic         dp_res_valid,
  input  logic [31:0]  dp_x_out,
  input  logic [31:0]  dp_y_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_x,
  output logic [31:0]  out_y,
  output logic         busy,
  output logic [15:0]  vtx_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_W  = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_e;

  state_e         state_q, state_d;
  logic           commit_pend_q, commit_pend_d;
  logic [31:0]    shadow_q [16];
  logic [31:0]    shadow_d [16];
  logic [31:0]    active_q [16];
  logic [31:0]    active_d [16];
  logic           issue_q, issue_d;
  logic [31:0]    dp_x_q, dp_x_d, dp_y_q, dp_y_d, dp_z_q, dp_z_d;
  logic [CW-1:0]  inflight_q, inflight_d;
  logic [CW-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]    vtx_q, vtx_d;
  logic [31:0]    fifo_x_q [FIFO_DEPTH];
  logic [31:0]    fifo_y_q [FIFO_DEPTH];

  logic           accept, push, pop;
  logic [CW:0]    occ;

  always_comb begin
    out_valid = (fifo_cnt_q != '0);
    pop       = out_valid & out_ready;
    push      = dp_res_valid & (inflight_q != '0);
    // The issue register holds a vertex not yet counted in flight; a pop this
    // cycle frees a slot early so back-to-back streaming is sustained.
    occ       = {1'b0, inflight_q} + {1'b0, fifo_cnt_q} + (CW+1)'(issue_q) - (CW+1)'(pop);
    in_ready  = reset_n & (state_q == RUN) & ~commit_pend_q & (occ < DEPTH_W);
    accept    = in_valid & in_ready;
  end

  always_comb begin
    state_d       = state_q;
    commit_pend_d = commit_pend_q | cfg_commit;
    cfg_done      = 1'b0;
    unique case (state_q)
      RUN:   if (commit_pend_q) state_d = DRAIN;
      DRAIN: if (inflight_q == '0 && !issue_q) state_d = SWAP;
      SWAP: begin
        state_d       = RUN;
        commit_pend_d = 1'b0;
        cfg_done      = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (cfg_wr) shadow_d[cfg_addr] = cfg_data;
    if (state_q == SWAP) active_d = shadow_q;
  end

  always_comb begin
    issue_d    = accept;
    dp_x_d     = accept ? in_x : dp_x_q;
    dp_y_d     = accept ? in_y : dp_y_q;
    dp_z_d     = accept ? in_z : dp_z_q;
    inflight_d = inflight_q + CW'(issue_q) - CW'(push);
    fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    vtx_d      = vtx_q + 16'(pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RUN;
      commit_pend_q <= 1'b0;
      issue_q       <= 1'b0;
      dp_x_q        <= '0;
      dp_y_q        <= '0;
      dp_z_q        <= '0;
      inflight_q    <= '0;
      fifo_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      vtx_q         <= '0;
      for (int unsigned i = 0; i < 16; i++) begin
        shadow_q[i] <= (i % 5 == 0) ? 32'd1 : '0;
        active_q[i] <= (i % 5 == 0) ? 32'd1 : '0;
      end
    end else begin
      state_q       <= state_d;
      commit_pend_q <= commit_pend_d;
      issue_q       <= issue_d;
      dp_x_q        <= dp_x_d;
      dp_y_q        <= dp_y_d;
      dp_z_q        <= dp_z_d;
      inflight_q    <= inflight_d;
      fifo_cnt_q    <= fifo_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      vtx_q         <= vtx_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_x_q[wr_ptr_q] <= dp_x_out;
      fifo_y_q[wr_ptr_q] <= dp_y_out;
    end
  end

  always_comb begin
    dp_matrix = '0;
    for (int unsigned i = 0; i < 16; i++) dp_matrix[32*i +: 32] = active_q[i];
  end

  assign dp_issue  = issue_q;
  assign dp_x      = dp_x_q;
  assign dp_y      = dp_y_q;
  assign dp_z      = dp_z_q;
  assign out_x     = fifo_x_q[rd_ptr_q];
  assign out_y     = fifo_y_q[rd_ptr_q];
  assign vtx_count = vtx_q;
  assign busy      = (inflight_q != '0) | out_valid | issue_q | (state_q != RUN);

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && fifo_cnt_q == FULL_CNT && !pop));
  a_inflight_bound: assert property (@(posedge clk) disable iff (!reset_n)
    inflight_q <= CW'(LAT));

endmodule

// File: tb/tb_vertex_xform_ctrl.sv
// Scoreboard bench for vertex_xform_ctrl with a LAT-stage affine datapath model.
module tb_vertex_xform_ctrl;
  localparam int unsigned LAT = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         cfg_wr = 1'b0, cfg_commit = 1'b0, cfg_done;
  logic [3:0]   cfg_addr = '0;
  logic [31:0]  cfg_data = '0;
  logic         in_valid = 1'b0, in_ready;
  logic [31:0]  in_x = '0, in_y = '0, in_z = '0;
  logic         dp_issue;
  logic [31:0]  dp_x, dp_y, dp_z;
  logic [511:0] dp_matrix;
  logic         dp_res_valid;
  logic [31:0]  dp_x_out, dp_y_out;
  logic         out_valid, out_ready = 1'b1;
  logic [31:0]  out_x, out_y;
  logic         busy;
  logic [15:0]  vtx_count;

  vertex_xform_ctrl #(.LAT(LAT), .FIFO_DEPTH(4), .CW(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_done(cfg_done),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .dp_issue(dp_issue), .dp_x(dp_x), .dp_y(dp_y), .dp_z(dp_z), .dp_matrix(dp_matrix),
    .dp_res_valid(dp_res_valid), .dp_x_out(dp_x_out), .dp_y_out(dp_y_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .busy(busy), .vtx_count(vtx_count)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0, acc0 = 0, last_acc = 0, done_cnt = 0;
  bit first_seen = 1'b0;
  logic [63:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cfg_done) done_cnt++;

  // Datapath model: rows 0/1 of the matrix applied to (x,y,z,1), captured at issue.
  logic [LAT-1:0] pv = '0;
  logic [31:0]    px [LAT];
  logic [31:0]    py [LAT];
  logic           inj = 1'b0;
  always @(posedge clk) begin
    pv[0] <= dp_issue;
    px[0] <= dp_matrix[31:0]*dp_x + dp_matrix[63:32]*dp_y + dp_matrix[95:64]*dp_z + dp_matrix[127:96];
    py[0] <= dp_matrix[159:128]*dp_x + dp_matrix[191:160]*dp_y + dp_matrix[223:192]*dp_z + dp_matrix[255:224];
    for (int i = 1; i < LAT; i++) begin
      pv[i] <= pv[i-1];
      px[i] <= px[i-1];
      py[i] <= py[i-1];
    end
  end
  assign dp_res_valid = pv[LAT-1] | inj;
  assign dp_x_out     = px[LAT-1];
  assign dp_y_out     = py[LAT-1];

  function automatic logic [511:0] ident();
    logic [511:0] m = '0;
    for (int i = 0; i < 16; i++) m[32*i +: 32] = (i % 5 == 0) ? 32'd1 : 32'd0;
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_wide(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every pop is compared against the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (!first_seen) begin
        first_seen = 1'b1;
        chk("first_latency", 64'(cyc - acc0), 64'd4);
      end
      if (exp_q.size() == 0) chk("unexpected_out", {out_x, out_y}, 64'hDEAD);
      else chk("out_xy", {out_x, out_y}, exp_q.pop_front());
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                      input logic [31:0] off, input logic commit);
    int n = 0;
    in_valid = 1'b1; in_x = x; in_y = y; in_z = z; cfg_commit = commit;
    @(negedge clk);
    while (!in_ready && n < 60) begin n++; @(negedge clk); end
    if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
    else begin
      last_acc = cyc;
      exp_q.push_back({x + off, y});
    end
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_commit = 1'b0;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_wr = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid || busy) && n < 200) begin n++; @(negedge clk); end
    chk("drain_timeout", 64'(n < 200), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    bit seen, done_seen, ready_bad;
    int d0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_outs", {59'd0, out_valid, dp_issue, cfg_done, busy, 1'b0}, 64'd0);
    chk("rst_vtx", 64'(vtx_count), 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rel_ready_busy", {62'd0, in_ready, busy}, 64'b10);
    chk_wide("rel_identity", dp_matrix, ident());
    @(posedge clk); #1;

    // Eight back-to-back vertices, identity matrix
    for (int i = 0; i < 8; i++) begin
      send(32'h100 + 32'(i), 32'h200 + 32'(i), 32'h300 + 32'(i), 32'd0, 1'b0);
      if (i == 0) acc0 = last_acc;
    end
    chk("stream_rate", 64'(last_acc - acc0), 64'd7);
    wait_drain();
    chk("vtx_after_stream", 64'(vtx_count), 64'd8);

    // Back-pressure: only four fit while the consumer stalls
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h400 + 32'(i), 32'h500 + 32'(i), 32'd7, 32'd0, 1'b0);
    in_valid = 1'b1; in_x = 32'h404; in_y = 32'h504; in_z = 32'd7;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (in_ready) seen = 1'b1; end
    chk("credit_block", 64'(seen), 64'd0);
    chk("fwft_head", {31'd0, out_valid, out_x}, {31'd0, 1'b1, 32'h400});
    @(posedge clk); #1 out_ready = 1'b1;
    send(32'h404, 32'h504, 32'd7, 32'd0, 1'b0);
    send(32'h405, 32'h505, 32'd7, 32'd0, 1'b0);
    wait_drain();
    chk("vtx_after_bp", 64'(vtx_count), 64'd14);

    // Commit with vertices in flight; the accept on the commit cycle uses the old matrix
    cfg_write(4'd3, 32'd10);
    chk("shadow_isolated", 64'(dp_matrix[127:96]), 64'd0);
    d0 = done_cnt;
    send(32'h600, 32'h601, 32'd1, 32'd0, 1'b0);
    send(32'h610, 32'h611, 32'd1, 32'd0, 1'b1);
    done_seen = 1'b0; ready_bad = 1'b0; n = 0;
    while (!done_seen && n < 40) begin
      @(negedge clk);
      if (in_ready) ready_bad = 1'b1;
      if (cfg_done) done_seen = 1'b1;
      n++;
    end
    chk("commit_done_seen", 64'(done_seen), 64'd1);
    chk("ready_low_in_commit", 64'(ready_bad), 64'd0);
    @(negedge clk);
    chk("ready_after_done", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    send(32'h620, 32'h621, 32'd1, 32'd10, 1'b0);
    @(negedge clk);
    chk("issue_new_matrix", {31'd0, dp_issue, dp_matrix[127:96]}, {31'd0, 1'b1, 32'd10});
    @(posedge clk); #1;
    wait_drain();
    chk("single_done_1", 64'(done_cnt - d0), 64'd1);

    // Double commit pulse collapses into one swap
    cfg_write(4'd3, 32'd20);
    d0 = done_cnt;
    cfg_commit = 1'b1;
    repeat (2) @(posedge clk);
    #1 cfg_commit = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("single_done_2", 64'(done_cnt - d0), 64'd1);
    send(32'h700, 32'h701, 32'd3, 32'd20, 1'b0);
    wait_drain();
    chk("vtx_before_rst", 64'(vtx_count), 64'd18);

    // Reset mid-operation
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h800 + 32'(i), 32'h900, 32'd0, 32'd20, 1'b0);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_outs", {46'd0, out_valid, in_ready, vtx_count}, 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    chk_wide("rst_mid_identity", dp_matrix, ident());
    inj = 1'b1;
    repeat (2) @(posedge clk);
    #1 inj = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    chk("stale_ignored", {62'd0, seen, busy}, 64'd0);
    @(posedge clk); #1;
    send(32'hA00, 32'hA01, 32'd5, 32'd0, 1'b0);
    wait_drain();
    chk("vtx_after_rst", 64'(vtx_count), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
